// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch types, PC constants and the next-PC select used by fetch and decode models
package cpu_pkg;
  localparam int WORD_W = 16;
  typedef enum logic [1:0] {BOOT, FETCH, DRAIN, HOLD} fetch_state_t;
  localparam logic [WORD_W-1:0] PC_INC = 16'd1;
  localparam logic [WORD_W-1:0] PC_RESET = 16'h0000;
  function automatic logic [WORD_W-1:0] next_pc(
    input logic              jump,
    input logic              branch_taken,
    input logic [WORD_W-1:0] jump_target,
    input logic [WORD_W-1:0] pc_branch,
    input logic [WORD_W-1:0] pc_count
  );
    return jump ? jump_target : branch_taken ? pc_branch : pc_count + PC_INC;
  endfunction
endpackage

// File: rtl/ifetch_unit.sv
// ifetch_unit: closes the PC loop, fetches over req/ack and buffers one instruction behind valid/ready
//   pc_count/pc_branch in, pc_next out (PC loads it every edge); imem_req/addr/ack/rdata memory side;
//   instr/instr_valid/instr_ready decoder side; branch_taken/jump/jump_target qualified by consume;
//   flush discards the buffered or in-flight word and refetches at pc_count
module ifetch_unit #(
  parameter int WORD_W = cpu_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] pc_count,
  input  logic [WORD_W-1:0] pc_branch,
  output logic [WORD_W-1:0] pc_next,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic [WORD_W-1:0] jump_target,
  input  logic              flush
);
  import cpu_pkg::*;
  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              consume;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req      = (state_q == FETCH) || (state_q == DRAIN);
    imem_addr     = imem_req ? pc_count : '0;
    consume       = (state_q == HOLD) && instr_valid_q && instr_ready && !flush;
    // The PC register loads every edge, so holding it means feeding pc_count straight back.
    pc_next       = (state_q == BOOT) ? PC_RESET
                  : consume ? next_pc(jump, branch_taken, jump_target, pc_branch, pc_count)
                  : pc_count;
    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        if (imem_ack && !flush) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end else if (flush && !imem_ack) begin
          state_d = DRAIN;
        end
      end
      // The abandoned request must still complete; its data is thrown away.
      DRAIN: state_d = imem_ack ? FETCH : DRAIN;
      HOLD: begin
        if (flush || consume) begin
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed checks of ifetch_unit with a bench-side PC register and memory
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_count = 16'h1234;
  logic [15:0] pc_branch;
  logic [15:0] pc_next;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic        jump;
  logic [15:0] jump_target;
  logic        flush;
  logic        ack_en;
  logic        pc_load;
  logic [15:0] pc_force;
  int          n_cmp = 0;
  int          n_bad = 0;

  ifetch_unit dut (
    .clk(clk), .rst(rst), .pc_count(pc_count), .pc_branch(pc_branch), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .jump(jump), .jump_target(jump_target), .flush(flush)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pc_count <= pc_load ? pc_force : pc_next;
  assign pc_branch = pc_count + 16'd2;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h0000) ? 16'h1111 : (a == 16'h0001) ? 16'h2222
         : (a == 16'h0005) ? 16'hDEAD : a ^ 16'hA5A5;
  endfunction
  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch_at(input logic [15:0] a);
    pc_load = 1'b1; pc_force = a; ack_en = 1'b0; instr_ready = 1'b0;
    tick;
    pc_load = 1'b0; ack_en = 1'b1;
    tick;
    ack_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ack_en = 1'b0; instr_ready = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; jump_target = 16'h0; pc_load = 1'b0; pc_force = 16'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst pc_next", pc_next, 16'h0000);
    chk("rst req", {15'd0, imem_req}, 16'd0);
    chk("rst addr", imem_addr, 16'h0000);
    chk("rst instr", instr, 16'h0000);
    chk("rst valid", {15'd0, instr_valid}, 16'd0);
    // zero-wait memory, decoder always ready
    rst = 1'b0; ack_en = 1'b1; instr_ready = 1'b1; pc_count = 16'h1234;
    #1;
    chk("boot pc_next", pc_next, 16'h0000);
    chk("boot req", {15'd0, imem_req}, 16'd0);
    tick; #1;
    chk("f0 req", {15'd0, imem_req}, 16'd1);
    chk("f0 addr", imem_addr, 16'h0000);
    chk("f0 pc_next", pc_next, 16'h0000);
    tick; #1;
    chk("h0 valid", {15'd0, instr_valid}, 16'd1);
    chk("h0 instr", instr, 16'h1111);
    chk("h0 pc_next", pc_next, 16'h0001);
    chk("h0 req", {15'd0, imem_req}, 16'd0);
    tick; #1;
    chk("f1 addr", imem_addr, 16'h0001);
    chk("f1 pc_next", pc_next, 16'h0001);
    tick; #1;
    chk("h1 instr", instr, 16'h2222);
    chk("h1 pc_next", pc_next, 16'h0002);
    ack_en = 1'b0;
    tick;
    // ack delayed 3 cycles, decoder late
    instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ack_en = (k == 3);
      #1;
      chk("wait req", {15'd0, imem_req}, 16'd1);
      chk("wait addr", imem_addr, 16'h0002);
      chk("wait pc_next", pc_next, 16'h0002);
      tick;
    end
    ack_en = 1'b0; jump = 1'b1; jump_target = 16'h0777; branch_taken = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("late req", {15'd0, imem_req}, 16'd0);
      chk("late valid", {15'd0, instr_valid}, 16'd1);
      chk("late pc_next", pc_next, 16'h0002);
      chk("late pc", pc_count, 16'h0002);
      tick;
    end
    jump = 1'b0; branch_taken = 1'b0; instr_ready = 1'b1;
    #1;
    chk("late consume", pc_next, 16'h0003);
    tick; #1;
    chk("late next addr", imem_addr, 16'h0003);
    // skip branch then jump overriding branch
    fetch_at(16'h0010);
    branch_taken = 1'b1; instr_ready = 1'b1;
    #1;
    chk("br pc_next", pc_next, 16'h0012);
    tick; #1;
    chk("br addr", imem_addr, 16'h0012);
    chk("br fetch pc_next", pc_next, 16'h0012);
    fetch_at(16'h0010);
    jump = 1'b1; jump_target = 16'h0100; branch_taken = 1'b1; instr_ready = 1'b1;
    #1;
    chk("jmp pc_next", pc_next, 16'h0100);
    tick; #1;
    chk("jmp addr", imem_addr, 16'h0100);
    jump = 1'b0; branch_taken = 1'b0;
    // sequential wrap
    fetch_at(16'hFFFF);
    instr_ready = 1'b1;
    #1;
    chk("wrap pc_next", pc_next, 16'h0000);
    tick; #1;
    chk("wrap addr", imem_addr, 16'h0000);
    // flush in the second wait cycle of a fetch at 0x0005
    pc_load = 1'b1; pc_force = 16'h0005; instr_ready = 1'b0;
    tick;
    pc_load = 1'b0;
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0; #1;
    chk("drain req", {15'd0, imem_req}, 16'd1);
    chk("drain addr", imem_addr, 16'h0005);
    chk("drain pc_next", pc_next, 16'h0005);
    ack_en = 1'b1;
    tick;
    ack_en = 1'b0; #1;
    chk("drain valid", {15'd0, instr_valid}, 16'd0);
    chk("drain instr", instr, 16'h5A5A);
    chk("refetch req", {15'd0, imem_req}, 16'd1);
    chk("refetch addr", imem_addr, 16'h0005);
    ack_en = 1'b1;
    tick;
    ack_en = 1'b0; #1;
    chk("refetch instr", instr, 16'hDEAD);
    chk("refetch valid", {15'd0, instr_valid}, 16'd1);
    // flush with ready in HOLD
    flush = 1'b1; instr_ready = 1'b1;
    #1;
    chk("hflush pc_next", pc_next, 16'h0005);
    tick;
    #1;
    chk("hflush valid", {15'd0, instr_valid}, 16'd0);
    chk("hflush addr", imem_addr, 16'h0005);
    chk("hflush req", {15'd0, imem_req}, 16'd1);
    // flush together with ack in FETCH drops the data
    ack_en = 1'b1;
    tick;
    flush = 1'b0; ack_en = 1'b0; #1;
    chk("fack valid", {15'd0, instr_valid}, 16'd0);
    chk("fack req", {15'd0, imem_req}, 16'd1);
    // async reset mid-fetch
    #1 rst = 1'b1;
    #1;
    chk("arst req", {15'd0, imem_req}, 16'd0);
    chk("arst pc_next", pc_next, 16'h0000);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("arst boot req", {15'd0, imem_req}, 16'd0);
    tick; #1;
    chk("arst refetch req", {15'd0, imem_req}, 16'd1);
    chk("arst refetch addr", imem_addr, 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch controller that closes the loop around the PC register. It reads `pc_count` and `pc_branch` from the PC and drives `pc_next` back every cycle, because the PC loads unconditionally on each rising edge. It fetches the word at `pc_count` from instruction memory over a req/ack handshake, buffers it for the decoder behind a valid/ready handshake, and selects sequential, skip-branch (BNE/BEQ) or jump successors.

## Interface
Parameters:
- `WORD_W`, 16: PC, address and instruction width.

Ports:
- `clk`  in  1  rising-edge clock shared with the PC register.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_count`  in  WORD_W  current PC from the PC register.
- `pc_branch`  in  WORD_W  `pc_count + 2` from the PC register (skip target).
- `pc_next`  out  WORD_W  next PC value; the PC register loads it every rising edge.
- `imem_req`  out  1  fetch request; held high until `imem_ack`.
- `imem_addr`  out  WORD_W  fetch address.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  WORD_W  fetched word.
- `instr`  out  WORD_W  buffered instruction to the decoder.
- `instr_valid`  out  1  `instr` holds an unconsumed instruction.
- `instr_ready`  in  1  decoder accepts `instr` this cycle.
- `branch_taken`  in  1  qualified by the consume cycle; the next PC is `pc_branch`.
- `jump`  in  1  qualified by the consume cycle; the next PC is `jump_target`. Overrides `branch_taken`.
- `jump_target`  in  WORD_W  absolute jump address.
- `flush`  in  1  discard the buffered or in-flight instruction and refetch at the current `pc_count`.

## Operation
- States: BOOT, FETCH, DRAIN, HOLD.
- BOOT (entered asynchronously on `rst`):
  - `pc_next`=0, `imem_req`=0, `instr_valid`=0.
  - Moves to FETCH on the first edge after `rst` falls.
  - This state resynchronises the PC to 0x0000.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc_count`, `pc_next`=`pc_count` (the PC holds).
  - `imem_ack` is sampled every cycle, including the first cycle of the request.
  - On ack: `instr`<=`imem_rdata`, `instr_valid`<=1, go to HOLD.
  - `flush` without ack: go to DRAIN.
  - `flush` together with ack: drop the data and stay in FETCH.
- DRAIN:
  - `imem_req`=1, same address, `pc_next`=`pc_count`.
  - On ack: discard the data and go to FETCH. `flush` here has no extra effect.
- HOLD:
  - `imem_req`=0, `instr_valid`=1, `pc_next`=`pc_count` until consume.
  - Consume = `instr_valid & instr_ready & !flush`. On consume, `instr_valid`<=0, go to FETCH, and `pc_next` is:
    - `jump_target` if `jump`;
    - else `pc_branch` if `branch_taken`;
    - else `pc_count + 1`.
  - `flush` in HOLD: `instr_valid`<=0, `pc_next`=`pc_count`, go to FETCH. This takes priority over `instr_ready`.
- Arithmetic: `pc_count + 1` is a WORD_W-bit sum and wraps 0xFFFF→0x0000. `pc_branch` is used as supplied, with no further arithmetic.
- `branch_taken`, `jump` and `jump_target` are ignored outside a consume cycle.
- When `imem_req`=0, `imem_addr` is 0.
- `instr` keeps its last value when not valid; it is 0 after reset.

## Timing
- Reset values: `pc_next`=0x0000, `imem_req`=0, `imem_addr`=0, `instr`=0x0000, `instr_valid`=0, state BOOT.
- `rst` mid-fetch drops `imem_req` immediately; instruction memory must tolerate abandoned requests.
- `pc_next` is combinational from state, `pc_count` and the consume inputs.
- `instr` and `instr_valid` are registered.
- Latency:
  - The ack edge sets `instr_valid` in the next cycle.
  - The consume edge loads the new PC.
  - The following cycle is FETCH at the new address.
- Zero-wait memory with an always-ready decoder gives 2 cycles per instruction (FETCH, HOLD).
- After `rst` falls: BOOT lasts one cycle, then the first `imem_req`=1 has `imem_addr`=0x0000.
- `imem_req` never deasserts before ack except on `rst`.
- While `imem_req`=1, `imem_addr` stays stable because the PC holds.

## Structure
- Shared package `cpu_pkg`:
  - `WORD_W`;
  - `fetch_state_t` enum {BOOT, FETCH, DRAIN, HOLD};
  - `PC_INC` = 16'd1;
  - `PC_RESET` = 16'h0000.
- Single module; no sub-module.
- The next-PC select is a small function in `cpu_pkg` so decode-side models can reuse it.

## Test plan
- Reset then zero-wait memory returning 0x1111 at 0x0000 and 0x2222 at 0x0001, decoder always ready: `instr` 0x1111 then 0x2222 on successive HOLD cycles; `pc_next` sequence 0, 0, 1, 1, 2.
- Memory ack delayed 3 cycles, decoder ready late: `imem_req` high for exactly 4 cycles with a stable address; `pc_next`=`pc_count` throughout; PC advances only on consume.
- Consume at `pc_count`=0x0010 with `pc_branch`=0x0012 and `branch_taken`=1: the next fetch address is 0x0012. Repeat with `jump`=1, `jump_target`=0x0100 and `branch_taken`=1: the next fetch address is 0x0100.
- `pc_count`=0xFFFF, sequential consume: `pc_next`=0x0000 and the next fetch address is 0x0000.
- `flush` in the second wait cycle of a fetch at 0x0005 returning 0xDEAD: the data is discarded with `instr_valid` staying 0; a new request goes out at 0x0005; no PC change.
- `flush` and `instr_ready` together in HOLD: no consume, `instr_valid` drops, refetch at the same address. Separately, `rst` pulse mid-FETCH: `imem_req` drops asynchronously and the fetch restarts at 0x0000.
